bcd_convert_scheduler: RTL and testbench
========================================

BCD_CONVERT_SCHEDULER -- requirements
Module: bcd_convert_scheduler

Interface
REQ-001 SHALL have parameter REFRESH_COUNT, default 1_000_000, meaning the number of clk cycles between forced re-conversions of both sources.
REQ-002 SHALL have parameter CONV_CYCLES, default 17, meaning the fixed latency of the shared converter from conv_start to conv_done.
REQ-003 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port src0_bin  input  16  binary value from requester 0 (switches).
REQ-006 SHALL have port src1_bin  input  16  binary value from requester 1 (alternate source).
REQ-007 SHALL have port mux_select  input  1  selects the cached result on bcd_out (0 = src0, 1 = src1).
REQ-008 SHALL have port bcd_out  output  20  five packed BCD digits of the selected source, most significant digit in [19:16].
REQ-009 SHALL have port bcd_valid  output  1  the selected cache entry has been written since reset.
REQ-010 SHALL have port busy  output  1  asserted while the FSM is outside IDLE.

Function
REQ-011 SHALL time-share one sub-module instance, bin_to_bcd_seq (shift-add-3, 16-bit in, 20-bit out), between both sources.
REQ-012 SHALL hold per-source state: snapshot[16] (last operand converted), cache[20], cvalid, pend.
REQ-013 SHALL set pend[i] on any cycle in which src_i_bin differs from snapshot[i], or on a refresh tick.
REQ-014 SHALL run a refresh counter from 0 to REFRESH_COUNT-1 that wraps to 0; the wrap cycle SHALL set both pend bits.
REQ-015 SHALL implement FSM states IDLE, LOAD, CONVERT, STORE.
REQ-016 IDLE -> LOAD when any pend bit is set; the granted source's input is captured into the operand register and into snapshot[i].
REQ-017 LOAD SHALL last exactly 1 cycle, asserting conv_start for that cycle only, then move to CONVERT.
REQ-018 CONVERT SHALL wait for conv_done (CONV_CYCLES cycles after conv_start), then move to STORE.
REQ-019 STORE SHALL last 1 cycle: write cache[i], set cvalid[i], clear pend[i] unless a new mismatch or tick occurs in that same cycle, advance the round-robin pointer, then return to IDLE.
REQ-020 Arbitration SHALL be round-robin when both are pending: the source not last granted wins; src0 wins first after reset.
REQ-021 A source change during its own conversion SHALL NOT abort that conversion; the mismatch against the new snapshot SHALL re-pend it.
REQ-022 From a source change while IDLE, cache SHALL update in at most CONV_CYCLES+3 = 20 cycles.
REQ-023 bcd_out and bcd_valid SHALL be registered: cache[mux_select] and cvalid[mux_select] appear one cycle after a select change or cache write.
REQ-024 busy SHALL be high during LOAD, CONVERT and STORE, and low in IDLE.

Reset
REQ-025 While reset=0 at a clock edge, the block SHALL enter IDLE and clear to 0: snapshots, caches, cvalid, pend, refresh counter, round-robin pointer (src0 next), bcd_out, bcd_valid, busy, conv_start.
REQ-026 Reset mid-conversion SHALL discard the operation, and the converter SHALL be reset with it.
REQ-027 After reset release, any nonzero input SHALL be converted, because the zeroed snapshots mismatch it.

Structure
REQ-028 A shared package bcd_sched_pkg SHALL hold the state enum and the constants BIN_W=16, BCD_W=20 and DEF_CONV_CYCLES=17.
REQ-029 bin_to_bcd_seq SHALL be the only sub-module, with ports clk, reset, conv_start, conv_bin, conv_done and conv_bcd; all other logic is in bcd_convert_scheduler.

Verification
REQ-030 After reset, src0_bin=16'h04D2 and mux_select=0 -> within 20 cycles bcd_out=20'h01234 and bcd_valid=1.
REQ-031 src0_bin=16'hFFFF -> bcd_out=20'h65535; with mux_select=1 before src1 is converted, bcd_valid=0.
REQ-032 src0=16'h0457 and src1=16'h15B3 changed in the same cycle -> src0 cached first (20'h01111), src1 one full slot later (20'h05555); toggling mux_select shows each value one cycle later.
REQ-033 src1 changed from 16'h0001 to 16'h0002 mid-conversion -> cache shows 20'h00001, then is re-converted to 20'h00002 with no lost update.
REQ-034 reset=0 held for 5 cycles mid-CONVERT -> all outputs 0 and busy=0; after release, the held inputs are reconverted correctly.
REQ-035 With REFRESH_COUNT=50 and inputs static -> busy pulses each 50 cycles with two back-to-back conversions and unchanged bcd_out.

Source files
------------

// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the time-shared binary-to-BCD conversion scheduler.
// Holds the FSM state encoding and the digit-adjust helper of the shift-add-3 converter.
package bcd_sched_pkg;

   localparam int BIN_W           = 16;
   localparam int BCD_W           = 20;
   localparam int DEF_CONV_CYCLES = 17;

   typedef logic [1:0] sched_state_t;

   localparam sched_state_t ST_IDLE    = 2'd0;
   localparam sched_state_t ST_LOAD    = 2'd1;
   localparam sched_state_t ST_CONVERT = 2'd2;
   localparam sched_state_t ST_STORE   = 2'd3;

   // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift
   function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] r;
      r = bcd;
      for (int d = 0; d < BCD_W / 4; d++) begin
         if (bcd[4*d +: 4] >= 4'd5) begin
            r[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_convert_scheduler_conv.sv
// Sequential shift-add-3 binary-to-BCD converter with a fixed start-to-done latency.
// One bit is shifted per cycle; the remaining cycles pad the latency out to CONV_CYCLES.
module bin_to_bcd_seq
   import bcd_sched_pkg::*;
#(
   parameter int CONV_CYCLES = DEF_CONV_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             conv_start,
   input  logic [BIN_W-1:0] conv_bin,
   output logic             conv_done,
   output logic [BCD_W-1:0] conv_bcd
);

   localparam int CNT_W = $clog2(CONV_CYCLES + 1);

   logic [CNT_W-1:0] cnt;
   logic             running;
   logic [BIN_W-1:0] shreg;
   logic [BCD_W-1:0] acc;
   logic [BCD_W-1:0] acc_adj;
   logic             shifting;

   assign acc_adj  = add3_digits(acc);
   assign shifting = running && (cnt <= CNT_W'(BIN_W));

   // cnt counts cycles since conv_start; shifting happens while cnt is 1..BIN_W
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt     <= '0;
         running <= 1'b0;
         shreg   <= '0;
         acc     <= '0;
      end else if (conv_start) begin
         cnt     <= CNT_W'(1);
         running <= 1'b1;
         shreg   <= conv_bin;
         acc     <= '0;
      end else if (running) begin
         if (shifting) begin
            acc   <= {acc_adj[BCD_W-2:0], shreg[BIN_W-1]};
            shreg <= {shreg[BIN_W-2:0], 1'b0};
         end
         if (cnt == CNT_W'(CONV_CYCLES)) begin
            running <= 1'b0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign conv_done = running && (cnt == CNT_W'(CONV_CYCLES));
   assign conv_bcd  = acc;

endmodule

// File: rtl/bcd_convert_scheduler.sv
// Shares one sequential BCD converter between two binary sources, caching each result.
// A source is re-converted whenever it differs from its last snapshot or on a periodic refresh.
module bcd_convert_scheduler
   import bcd_sched_pkg::*;
#(
   parameter int REFRESH_COUNT = 1_000_000,
   parameter int CONV_CYCLES   = DEF_CONV_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [BIN_W-1:0] src0_bin,
   input  logic [BIN_W-1:0] src1_bin,
   input  logic             mux_select,
   output logic [BCD_W-1:0] bcd_out,
   output logic             bcd_valid,
   output logic             busy
);

   localparam int RC_W = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;

   sched_state_t     state;
   logic [BIN_W-1:0] src_bin  [2];
   logic [BIN_W-1:0] snapshot [2];
   logic [BCD_W-1:0] cache    [2];
   logic [1:0]       cvalid;
   logic [1:0]       pend;
   logic [1:0]       pend_next;
   logic [1:0]       mismatch;
   logic [1:0]       need;
   logic [RC_W-1:0]  refresh_cnt;
   logic             refresh_tick;
   logic             rr_next;
   logic             gnt_sel;
   logic             gnt_idx;
   logic [BIN_W-1:0] operand;
   logic             conv_start;
   logic             conv_done;
   logic [BCD_W-1:0] conv_bcd;

   assign src_bin[0]   = src0_bin;
   assign src_bin[1]   = src1_bin;
   assign mismatch[0]  = (src0_bin != snapshot[0]);
   assign mismatch[1]  = (src1_bin != snapshot[1]);
   assign refresh_tick = (refresh_cnt == RC_W'(REFRESH_COUNT - 1));
   // IDLE also honours a mismatch seen this very cycle so a change starts converting immediately
   assign need         = pend | mismatch | {2{refresh_tick}};
   assign busy         = (state != ST_IDLE);

   always_comb begin
      if (&need) begin
         gnt_sel = rr_next;
      end else begin
         gnt_sel = ~need[0];
      end
   end

   always_comb begin
      pend_next = pend | mismatch | {2{refresh_tick}};
      if (state == ST_STORE) begin
         pend_next[gnt_idx] = mismatch[gnt_idx] | refresh_tick;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         snapshot[0] <= '0;
         snapshot[1] <= '0;
         cache[0]    <= '0;
         cache[1]    <= '0;
         cvalid      <= '0;
         pend        <= '0;
         refresh_cnt <= '0;
         rr_next     <= 1'b0;
         gnt_idx     <= 1'b0;
         operand     <= '0;
         conv_start  <= 1'b0;
         bcd_out     <= '0;
         bcd_valid   <= 1'b0;
      end else begin
         conv_start  <= 1'b0;
         pend        <= pend_next;
         refresh_cnt <= refresh_tick ? '0 : refresh_cnt + RC_W'(1);
         bcd_out     <= cache[mux_select];
         bcd_valid   <= cvalid[mux_select];
         case (state)
            ST_IDLE: begin
               if (|need) begin
                  gnt_idx           <= gnt_sel;
                  operand           <= src_bin[gnt_sel];
                  snapshot[gnt_sel] <= src_bin[gnt_sel];
                  conv_start        <= 1'b1;
                  state             <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               state <= ST_CONVERT;
            end
            ST_CONVERT: begin
               if (conv_done) begin
                  state <= ST_STORE;
               end
            end
            ST_STORE: begin
               cache[gnt_idx]  <= conv_bcd;
               cvalid[gnt_idx] <= 1'b1;
               rr_next         <= ~gnt_idx;
               state           <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   bin_to_bcd_seq #(
      .CONV_CYCLES (CONV_CYCLES)
   ) u_conv (
      .clk        (clk),
      .reset      (reset),
      .conv_start (conv_start),
      .conv_bin   (operand),
      .conv_done  (conv_done),
      .conv_bcd   (conv_bcd)
   );

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Self-checking bench for bcd_convert_scheduler: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model using decimal arithmetic.
module tb_bcd_convert_scheduler;

   localparam int REFRESH = 50;
   localparam int CONV    = 17;

   logic        clk;
   logic        rst_n;
   logic [15:0] src0;
   logic [15:0] src1;
   logic        sel;
   logic [19:0] bcd_out;
   logic        bcd_valid;
   logic        busy;

   int n_compared;
   int n_mismatched;
   bit check_en;

   bcd_convert_scheduler #(
      .REFRESH_COUNT (REFRESH),
      .CONV_CYCLES   (CONV)
   ) dut (
      .clk        (clk),
      .reset      (rst_n),
      .src0_bin   (src0),
      .src1_bin   (src1),
      .mux_select (sel),
      .bcd_out    (bcd_out),
      .bcd_valid  (bcd_valid),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      int x;
      x = v;
      r = '0;
      for (int d = 0; d < 5; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Transaction model: a granted job occupies CONV+2 busy cycles, the last one writing the cache
   logic [15:0] m_snap  [2];
   logic [19:0] m_cache [2];
   logic [15:0] m_src   [2];
   bit   [1:0]  m_cv;
   bit   [1:0]  m_pend;
   bit          m_rr;
   bit          m_gnt;
   logic [15:0] m_op;
   int          m_busy_cnt;
   int          m_ref;
   logic [19:0] m_bcd_out;
   bit          m_valid;
   bit          m_tick;
   bit   [1:0]  m_mis;
   bit   [1:0]  m_need;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_snap[i]  = '0;
            m_cache[i] = '0;
         end
         m_cv       = '0;
         m_pend     = '0;
         m_rr       = 1'b0;
         m_gnt      = 1'b0;
         m_op       = '0;
         m_busy_cnt = 0;
         m_ref      = 0;
         m_bcd_out  = '0;
         m_valid    = 1'b0;
      end else begin
         m_src[0]  = src0;
         m_src[1]  = src1;
         m_tick    = (m_ref == REFRESH - 1);
         m_mis[0]  = (src0 != m_snap[0]);
         m_mis[1]  = (src1 != m_snap[1]);
         m_bcd_out = m_cache[sel];
         m_valid   = m_cv[sel];
         m_need    = m_pend | m_mis | {2{m_tick}};
         m_pend    = m_need;
         if (m_busy_cnt == 1) begin
            m_pend[m_gnt]  = m_mis[m_gnt] | m_tick;
            m_cache[m_gnt] = to_bcd(int'(m_op));
            m_cv[m_gnt]    = 1'b1;
            m_rr           = ~m_gnt;
         end
         if (m_busy_cnt > 0) begin
            m_busy_cnt = m_busy_cnt - 1;
         end else if (m_need != 2'b00) begin
            m_gnt         = (m_need == 2'b11) ? m_rr : (m_need == 2'b10);
            m_op          = m_src[m_gnt];
            m_snap[m_gnt] = m_src[m_gnt];
            m_busy_cnt    = CONV + 2;
         end
         m_ref = m_tick ? 0 : m_ref + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [19:0] got, input logic [19:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("model_bcd_out", bcd_out, m_bcd_out);
         checkOutput("model_bcd_valid", {19'd0, bcd_valid}, {19'd0, m_valid});
         checkOutput("model_busy", {19'd0, busy}, {19'd0, (m_busy_cnt > 0)});
      end
   end

   task automatic applyStimulus(input logic [15:0] s0, input logic [15:0] s1, input logic s);
      src0 = s0;
      src1 = s1;
      sel  = s;
   endtask

   task automatic holdReset(input int cycles);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic waitForValue(input string name, input logic [19:0] exp, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (bcd_valid && bcd_out == exp) seen = 1'b1;
      end
      checkOutput(name, seen ? bcd_out : 20'hFFFFF, exp);
   endtask

   initial begin
      int rises;
      logic prev_busy;
      logic [19:0] held;
      rst_n = 1'b0;
      applyStimulus(16'h0000, 16'h0000, 1'b0);
      n_compared   = 0;
      n_mismatched = 0;
      check_en     = 1'b0;
      repeat (3) @(negedge clk);
      check_en = 1'b1;
      checkOutput("reset_bcd_out", bcd_out, 20'h00000);
      checkOutput("reset_valid", {19'd0, bcd_valid}, 20'h0);
      checkOutput("reset_busy", {19'd0, busy}, 20'h0);

      // 1234 on src0 right after release
      rst_n = 1'b1;
      applyStimulus(16'h04D2, 16'h0000, 1'b0);
      waitForValue("conv_1234", 20'h01234, 22);

      // 65535 on src0, src1 never converted yet
      holdReset(2);
      rst_n = 1'b1;
      applyStimulus(16'hFFFF, 16'h0000, 1'b1);
      repeat (3) @(negedge clk);
      checkOutput("src1_not_valid", {19'd0, bcd_valid}, 20'h0);
      sel = 1'b0;
      waitForValue("conv_65535", 20'h65535, 22);

      // Both change together: src0 first, src1 a slot later
      holdReset(2);
      rst_n = 1'b1;
      applyStimulus(16'h0457, 16'h15B3, 1'b0);
      waitForValue("rr_src0_first", 20'h01111, 22);
      sel = 1'b1;
      @(negedge clk);
      checkOutput("src1_pending", {19'd0, bcd_valid}, 20'h0);
      waitForValue("rr_src1_second", 20'h05555, 25);
      sel = 1'b0;
      @(negedge clk);
      checkOutput("select_latency", bcd_out, 20'h01111);

      // src1 changes while its own conversion is running
      holdReset(2);
      rst_n = 1'b1;
      applyStimulus(16'h0000, 16'h0001, 1'b1);
      repeat (5) @(negedge clk);
      src1 = 16'h0002;
      waitForValue("midconv_first", 20'h00001, 22);
      waitForValue("midconv_reconv", 20'h00002, 25);

      // Reset held mid-conversion, then reconversion of the held inputs
      holdReset(2);
      rst_n = 1'b1;
      applyStimulus(16'd9999, 16'd42, 1'b0);
      waitForValue("pre_reset_9999", 20'h09999, 22);
      sel = 1'b1;
      repeat (8) @(negedge clk);
      holdReset(5);
      checkOutput("midreset_bcd_out", bcd_out, 20'h00000);
      checkOutput("midreset_valid", {19'd0, bcd_valid}, 20'h0);
      checkOutput("midreset_busy", {19'd0, busy}, 20'h0);
      rst_n = 1'b1;
      waitForValue("post_reset_42", 20'h00042, 45);
      sel = 1'b0;
      waitForValue("post_reset_9999", 20'h09999, 45);

      // Static inputs: refresh keeps re-converting both sources, output steady
      holdReset(2);
      rst_n = 1'b1;
      applyStimulus(16'd77, 16'd88, 1'b0);
      waitForValue("static_77", 20'h00077, 22);
      repeat (30) @(negedge clk);
      held      = bcd_out;
      rises     = 0;
      prev_busy = busy;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (busy && !prev_busy) rises++;
         prev_busy = busy;
         checkOutput("static_hold", bcd_out, 20'h00077);
      end
      checkOutput("refresh_pulses", 20'((rises >= 4 && rises <= 7) ? 1 : 0), 20'd1);
      if (held != 20'h00077) checkOutput("static_start", held, 20'h00077);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
         end else if (!rst_n && $urandom_range(0, 2) == 0) begin
            rst_n = 1'b1;
         end
         if ($urandom_range(0, 9) == 0) src0 = 16'($urandom);
         if ($urandom_range(0, 9) == 0) src1 = 16'($urandom_range(0, 99));
         if ($urandom_range(0, 5) == 0) sel = ~sel;
      end
      rst_n = 1'b1;
      repeat (60) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
